capture_controller: RTL and testbench

Sequencer for the logic-analyzer datapath. It sits between the command decoder and the UART transmitter and owns an internal circular sample buffer. It accepts decoded opcode/command words and holds sample-rate, trigger and count configuration. It runs the arm → trigger → post-trigger capture → UART dump sequence and answers the ID query.

---
 rtl/capture_controller.sv | 196 +++++++++++++++++++
 tb/tb_capture_controller.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_controller.sv
// Logic-analyzer capture sequencer: holds configuration, samples probe into a
// circular buffer on a divided strobe, waits for a trigger, then dumps newest-first.
module capture_controller #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [7:0]  opcode,
  input  logic [31:0] command,
  input  logic [7:0]  probe,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        armed,
  output logic        triggered,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_DUMP    = 3'd3,
    S_ID      = 3'd4
  } state_t;

  localparam logic [16:0] DEPTH_17 = DEPTH[16:0];
  localparam logic [AW:0] DEPTH_L  = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  state_t       state;
  logic [23:0]  divider;
  logic [15:0]  read_count;
  logic [15:0]  delay_count;
  logic [7:0]   trig_mask;
  logic [7:0]   trig_value;

  logic [23:0]  scnt;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]  remaining;
  logic [15:0]  dcnt;
  logic [1:0]   dphase;
  logic [1:0]   id_idx;

  logic [7:0]   mem [DEPTH];
  logic [7:0]   rdata;

  logic         soft_rst;
  logic         sampling;
  logic         strobe;
  logic         we;
  logic         match;
  logic [AW:0]  dump_len;

  function automatic logic [7:0] id_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    id_byte = 8'h31;
      2'd1:    id_byte = 8'h41;
      2'd2:    id_byte = 8'h4C;
      default: id_byte = 8'h53;
    endcase
  endfunction

  always_comb begin
    soft_rst = cmd_valid && (opcode == 8'h00);
    sampling = (state == S_ARMED) || (state == S_CAPTURE);
    strobe   = sampling && (scnt == 24'd0);
    we       = strobe && !soft_rst;
    match    = ((probe ^ trig_value) & trig_mask) == 8'h00;
    dump_len = ({1'b0, read_count} > DEPTH_17) ? DEPTH_L : read_count[AW:0];
  end

  assign armed     = (state == S_ARMED);
  assign triggered = (state == S_CAPTURE) || (state == S_DUMP);
  assign state_out = state;

  // Sample buffer: no reset, one-cycle registered read.
  always_ff @(posedge clock) begin
    if (we) mem[wptr] <= probe;
    rdata <= mem[rptr];
  end

  // tx handshake: tx_start/tx_data stay put until a cycle with tx_ready high;
  // that cycle transfers the byte and tx_start drops for at least one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      divider     <= 24'd0;
      read_count  <= 16'd0;
      delay_count <= 16'd0;
      trig_mask   <= 8'h00;
      trig_value  <= 8'h00;
      scnt        <= 24'd0;
      wptr        <= '0;
      rptr        <= '0;
      remaining   <= '0;
      dcnt        <= 16'd0;
      dphase      <= 2'd0;
      id_idx      <= 2'd0;
    end else begin
      if (we) wptr <= wptr + PTR_ONE;
      if (sampling) scnt <= (scnt == divider) ? 24'd0 : scnt + 24'd1;

      if (soft_rst) begin
        state    <= S_IDLE;
        tx_start <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_valid) begin
              case (opcode)
                8'h01: begin
                  state <= S_ARMED;
                  scnt  <= 24'd0;
                end
                8'h02: begin
                  state    <= S_ID;
                  id_idx   <= 2'd0;
                  tx_start <= 1'b1;
                  tx_data  <= 8'h31;
                end
                8'h80: divider <= command[23:0];
                8'h81: begin
                  read_count  <= command[15:0];
                  delay_count <= command[31:16];
                end
                8'hC0: trig_mask  <= command[7:0];
                8'hC1: trig_value <= command[7:0];
                default: ;
              endcase
            end
          end
          S_ARMED: begin
            if (strobe && match) begin
              dcnt      <= delay_count;
              rptr      <= wptr;
              remaining <= dump_len;
              dphase    <= 2'd0;
              state     <= (delay_count == 16'd0) ? S_DUMP : S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (strobe) begin
              rptr <= wptr;
              dcnt <= dcnt - 16'd1;
              if (dcnt == 16'd1) state <= S_DUMP;
            end
          end
          S_DUMP: begin
            // Phase 0 presents the address, phase 1 loads the read data, phase 2 waits.
            case (dphase)
              2'd0: begin
                if (remaining == '0) state <= S_IDLE;
                else dphase <= 2'd1;
              end
              2'd1: begin
                tx_data  <= rdata;
                tx_start <= 1'b1;
                rptr     <= rptr - PTR_ONE;
                dphase   <= 2'd2;
              end
              default: begin
                if (tx_ready) begin
                  tx_start  <= 1'b0;
                  remaining <= remaining - CNT_ONE;
                  if (remaining == CNT_ONE) state <= S_IDLE;
                  else dphase <= 2'd1;
                end
              end
            endcase
          end
          S_ID: begin
            if (tx_start) begin
              if (tx_ready) begin
                tx_start <= 1'b0;
                id_idx   <= id_idx + 2'd1;
                if (id_idx == 2'd3) state <= S_IDLE;
              end
            end else begin
              tx_start <= 1'b1;
              tx_data  <= id_byte(id_idx);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller: scenario tasks checked against a sample-index
// model of the capture (strobe spacing, trigger search, newest-first dump).
module tb_capture_controller;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [7:0]  opcode = 8'h00;
  logic [31:0] command = 32'h0;
  logic [7:0]  probe = 8'h00;
  logic        tx_ready = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        armed;
  logic        triggered;
  logic [2:0]  state_out;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prb [4096];
  int cfg_div, cfg_read, cfg_delay;
  logic [7:0] cfg_mask, cfg_val;

  capture_controller #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .opcode(opcode),
    .command(command), .probe(probe), .tx_ready(tx_ready), .tx_start(tx_start),
    .tx_data(tx_data), .armed(armed), .triggered(triggered), .state_out(state_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1; opcode = op; command = arg;
    step();
    cmd_valid = 1'b0; opcode = 8'h00; command = 32'h0;
  endtask

  task automatic configure(input int d, input int rd, input int dl,
                           input logic [7:0] m, input logic [7:0] v);
    cfg_div = d; cfg_read = rd; cfg_delay = dl; cfg_mask = m; cfg_val = v;
    send_cmd(8'h80, 32'(d));
    send_cmd(8'h81, {dl[15:0], rd[15:0]});
    send_cmd(8'hC0, {24'd0, m});
    send_cmd(8'hC1, {24'd0, v});
  endtask

  // Samples are prb[i*(div+1)]; first match index j, then delay more samples.
  task automatic build_expected(output int trig_cyc, output int dump_cyc, output int n);
    int sl, j, total, idx;
    sl = cfg_div + 1;
    j = -1;
    for (int i = 0; (i * sl < 4096) && (j < 0); i++)
      if ((prb[i * sl] & cfg_mask) == (cfg_val & cfg_mask)) j = i;
    if (j < 0) j = 0;
    total = j + cfg_delay + 1;
    n = (cfg_read > DEPTH) ? DEPTH : cfg_read;
    exp_q.delete();
    for (int m = 0; m < n; m++) begin
      idx = (total - 1 - m) * sl;
      if (idx >= 0) exp_q.push_back(prb[idx]);
    end
    trig_cyc = j * sl;
    dump_cyc = (total - 1) * sl + 1;
  endtask

  task automatic do_run(input string name, input bit rand_ready);
    int tc, dc, n, got, trig_seen, dump_seen, first_tx;
    bit done, prev_hold, prev_acc;
    logic [7:0] prev_data, e;
    build_expected(tc, dc, n);
    got = 0; trig_seen = -1; dump_seen = -1; first_tx = -1;
    done = 0; prev_hold = 0; prev_acc = 0; prev_data = 8'h00;
    send_cmd(8'h01, 32'h0);
    for (int c = 0; c < 20000; c++) begin
      if (c == 0) begin
        checks++;
        if (state_out !== 3'd1 || armed !== 1'b1) begin
          failures++;
          $display("FAIL %s arm: state_out=%0d armed=%b, expected 1 and 1", name, state_out, armed);
        end
      end
      if (c == tc) begin
        checks++;
        if (armed !== 1'b1) begin
          failures++;
          $display("FAIL %s armed_at_trigger: armed=%b at cycle %0d, expected 1", name, armed, c);
        end
      end
      if (trig_seen < 0 && triggered === 1'b1) trig_seen = c;
      if (dump_seen < 0 && state_out === 3'd3) dump_seen = c;
      if (first_tx < 0 && tx_start === 1'b1) first_tx = c;
      if (prev_hold) begin
        checks++;
        if (tx_start !== 1'b1 || tx_data !== prev_data) begin
          failures++;
          $display("FAIL %s hold: tx_start=%b tx_data=%h, expected 1 and %h", name, tx_start, tx_data, prev_data);
        end
      end
      if (prev_acc) begin
        checks++;
        if (tx_start !== 1'b0) begin
          failures++;
          $display("FAIL %s gap: tx_start=%b after accept, expected 0", name, tx_start);
        end
      end
      if (state_out === 3'd0) begin
        done = 1;
        break;
      end
      probe = (c < 4096) ? prb[c] : 8'h00;
      tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_acc = tx_start && tx_ready;
      prev_hold = tx_start && !tx_ready;
      prev_data = tx_data;
      if (prev_acc) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL %s extra_byte: got %h, expected no more bytes", name, tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            failures++;
            $display("FAIL %s byte%0d: got %h, expected %h", name, got, tx_data, e);
          end
        end
      end
      step();
    end
    tx_ready = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s timeout: no return to IDLE, got %0d bytes, expected %0d", name, got, n);
    end
    checks++;
    if (trig_seen != tc + 1) begin
      failures++;
      $display("FAIL %s trigger_cycle: got %0d, expected %0d", name, trig_seen, tc + 1);
    end
    checks++;
    if (dump_seen != dc) begin
      failures++;
      $display("FAIL %s dump_entry: got %0d, expected %0d", name, dump_seen, dc);
    end
    checks++;
    if (got != n) begin
      failures++;
      $display("FAIL %s byte_count: got %0d, expected %0d", name, got, n);
    end
    if (n > 0) begin
      checks++;
      if (first_tx != dc + 2) begin
        failures++;
        $display("FAIL %s first_tx: got cycle %0d, expected %0d", name, first_tx, dc + 2);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    checks++;
    if ({tx_start, tx_data, armed, triggered, state_out} !== 14'h0) begin
      failures++;
      $display("FAIL reset_outputs: tx_start=%b tx_data=%h armed=%b triggered=%b state_out=%0d, expected all 0",
               tx_start, tx_data, armed, triggered, state_out);
    end
    reset = 1'b1;
    step();
    checks++;
    if (state_out !== 3'd0 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: state_out=%0d tx_start=%b, expected 0 and 0", state_out, tx_start);
    end
  endtask

  task automatic test_soft_during_id();
    send_cmd(8'h02, 32'h0);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h31) begin
      failures++;
      $display("FAIL soft_id_first: tx_start=%b tx_data=%h, expected 1 and 31", tx_start, tx_data);
    end
    tx_ready = 1'b1; cmd_valid = 1'b1; opcode = 8'h00;
    step();
    cmd_valid = 1'b0; tx_ready = 1'b0;
    checks++;
    if (state_out !== 3'd0 || tx_start !== 1'b0) begin
      failures++;
      $display("FAIL soft_id_abort: state_out=%0d tx_start=%b, expected 0 and 0", state_out, tx_start);
    end
  endtask

  task automatic test_id();
    int got;
    bit done;
    logic [7:0] e;
    got = 0; done = 0;
    exp_q = {8'h31, 8'h41, 8'h4C, 8'h53};
    tx_ready = 1'b1;
    send_cmd(8'h02, 32'h0);
    checks++;
    if (state_out !== 3'd4) begin
      failures++;
      $display("FAIL id_enter: state_out=%0d, expected 4", state_out);
    end
    for (int c = 0; c < 100; c++) begin
      if (state_out === 3'd0) begin
        done = 1;
        break;
      end
      checks++;
      if (state_out !== 3'd4) begin
        failures++;
        $display("FAIL id_state: state_out=%0d, expected 4", state_out);
      end
      if (tx_start === 1'b1) begin
        got++;
        checks++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        if (tx_data !== e) begin
          failures++;
          $display("FAIL id_byte%0d: got %h, expected %h", got, tx_data, e);
        end
      end
      step();
    end
    tx_ready = 1'b0;
    checks++;
    if (!done || got != 4) begin
      failures++;
      $display("FAIL id_count: done=%0d bytes=%0d, expected 1 and 4", done, got);
    end
  endtask

  task automatic test_immediate_trigger();
    for (int c = 0; c < 4096; c++) prb[c] = 8'(16 + c);
    configure(0, 4, 3, 8'h00, 8'h00);
    do_run("immediate", 1'b0);
  endtask

  task automatic test_pattern_trigger();
    for (int c = 0; c < 4096; c++) prb[c] = (c < 10) ? 8'h00 : 8'hA5;
    configure(1, 2, 0, 8'hF0, 8'hA0);
    do_run("pattern", 1'b0);
  endtask

  task automatic test_config_busy();
    configure(0, 4, 3, 8'h01, 8'h01);
    probe = 8'h00;
    send_cmd(8'h01, 32'h0);
    repeat (3) step();
    send_cmd(8'hC0, 32'h0);
    repeat (4) step();
    checks++;
    if (state_out !== 3'd1 || armed !== 1'b1) begin
      failures++;
      $display("FAIL busy_cfg: state_out=%0d armed=%b, expected 1 and 1", state_out, armed);
    end
    send_cmd(8'h00, 32'h0);
    checks++;
    if (state_out !== 3'd0 || armed !== 1'b0) begin
      failures++;
      $display("FAIL busy_soft: state_out=%0d armed=%b, expected 0 and 0", state_out, armed);
    end
  endtask

  task automatic test_random();
    int d, dl, jf, sl;
    logic [7:0] m, v;
    for (int it = 0; it < 4; it++) begin
      d = $urandom_range(0, 3);
      dl = $urandom_range(0, 6);
      m = 8'($urandom_range(1, 255));
      v = 8'($urandom);
      sl = d + 1;
      for (int c = 0; c < 4096; c++) prb[c] = 8'($urandom);
      jf = $urandom_range(0, 20);
      prb[jf * sl] = (v & m) | (prb[jf * sl] & ~m);
      configure(d, $urandom_range(0, dl + 1), dl, m, v);
      do_run("random", 1'b1);
    end
  endtask

  task automatic test_clip_backpressure();
    for (int c = 0; c < 4096; c++) prb[c] = 8'($urandom);
    configure(0, 16'hFFFF, 1100, 8'h00, 8'h00);
    do_run("clip", 1'b1);
  endtask

  task automatic test_async_reset();
    int got;
    bit hit;
    got = 0; hit = 0;
    configure(0, 20, 19, 8'h01, 8'h01);
    probe = 8'hFF;
    tx_ready = 1'b1;
    send_cmd(8'h01, 32'h0);
    for (int c = 0; c < 500; c++) begin
      if (got == 5 && tx_start === 1'b1) begin
        hit = 1;
        break;
      end
      if (tx_start === 1'b1) got++;
      step();
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL arst_reach: bytes=%0d before sixth offer, expected 5", got);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({tx_start, tx_data, armed, triggered, state_out} !== 14'h0) begin
      failures++;
      $display("FAIL arst_outputs: tx_start=%b tx_data=%h armed=%b triggered=%b state_out=%0d, expected all 0",
               tx_start, tx_data, armed, triggered, state_out);
    end
    tx_ready = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    checks++;
    if (state_out !== 3'd0) begin
      failures++;
      $display("FAIL arst_release: state_out=%0d, expected 0", state_out);
    end
    cfg_div = 0; cfg_read = 0; cfg_delay = 0; cfg_mask = 8'h00; cfg_val = 8'h00;
    for (int c = 0; c < 4096; c++) prb[c] = 8'h00;
    do_run("defaults", 1'b0);
  endtask

  initial begin
    test_reset();
    test_soft_during_id();
    test_id();
    test_immediate_trigger();
    test_pattern_trigger();
    test_config_busy();
    test_random();
    test_clip_backpressure();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
